// File: rtl/sha_pad_feeder.sv
// SHA-256 message front end: collects message bytes, applies padding and
// length, then presents each 512-bit block as 16 words (load phase) followed
// by the 64-cycle expansion phase and a one-cycle block-done phase.
module sha_pad_feeder #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  input  logic                  byte_last_in,
  output logic                  byte_ready_out,
  input  logic                  empty_msg_in,
  input  logic                  core_ready_in,
  output logic [2:0]            FSM_core_out,
  output logic [6:0]            core_count_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  block_last_out,
  output logic                  msg_done_out
);

  localparam int unsigned BLK_BYTES = 64;
  localparam int unsigned PTR_W     = 6;
  localparam int unsigned CNT_W     = 61;
  localparam int unsigned IDX_W     = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_PAD,
    S_WAIT,
    S_LOAD,
    S_EXPAND,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         blk_q [BLK_BYTES];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               one_q, one_d;     // 0x80 already written for this message
  logic               pend_q, pend_d;   // another padding block must follow
  logic               final_q, final_d; // buffered block carries the length
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               ready_q, ready_d;
  logic [2:0]         fsm_q, fsm_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic               blast_q, blast_d;
  logic               done_q, done_d;

  logic               we;
  logic [7:0]         wdata;
  logic               accept;
  logic [63:0]        len_bits;
  logic [7:0]         len_byte;
  logic [3:0]         wsel;
  logic [31:0]        word;

  // Phase code presented to the compression side for a given state.
  function automatic logic [2:0] phase_of(input state_e s);
    case (s)
      S_COLLECT, S_PAD, S_WAIT: phase_of = 3'b001;
      S_LOAD:                   phase_of = 3'b010;
      S_EXPAND:                 phase_of = 3'b011;
      S_DONE:                   phase_of = 3'b100;
      default:                  phase_of = 3'b000;
    endcase
  endfunction

  // Next-state, buffer write and registered-output decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    one_d    = one_q;
    pend_d   = pend_q;
    final_d  = final_q;
    idx_d    = idx_q;
    we       = 1'b0;
    wdata    = byte_in;
    accept   = byte_valid_in && ready_q;
    len_bits = {cnt_q, 3'b000};
    len_byte = 8'(len_bits >> {6'd63 - ptr_q, 3'b000});

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we      = 1'b1;
          ptr_d   = PTR_W'(1);
          cnt_d   = CNT_W'(1);
          state_d = byte_last_in ? S_PAD : S_COLLECT;
        end else if (empty_msg_in) begin
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = S_PAD;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          we    = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          // A last byte that fills the block still needs a padding block.
          if (ptr_q == 6'd63) begin
            pend_d  = byte_last_in;
            state_d = S_WAIT;
          end else if (byte_last_in) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        we    = 1'b1;
        ptr_d = ptr_q + PTR_W'(1);
        if (!one_q) begin
          wdata = 8'h80;
          one_d = 1'b1;
          if (ptr_q >= 6'd56) pend_d = 1'b1;
        end else if (ptr_q >= 6'd56 && !pend_q) begin
          wdata = len_byte;
        end else begin
          wdata = 8'h00;
        end
        if (ptr_q == 6'd63) begin
          final_d = !pend_d;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_ready_in) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (idx_q == IDX_W'(15)) begin
          idx_d   = '0;
          state_d = S_EXPAND;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_EXPAND: begin
        if (idx_q == IDX_W'(63)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        ptr_d = '0;
        if (final_q) begin
          cnt_d   = '0;
          one_d   = 1'b0;
          pend_d  = 1'b0;
          final_d = 1'b0;
          state_d = S_IDLE;
        end else if (pend_q) begin
          pend_d  = 1'b0;
          state_d = S_PAD;
        end else begin
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wsel    = idx_d[3:0];
    word    = {blk_q[{wsel, 2'd0}], blk_q[{wsel, 2'd1}],
               blk_q[{wsel, 2'd2}], blk_q[{wsel, 2'd3}]};
    ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
    fsm_d   = phase_of(state_d);
    count_d = (state_d == S_LOAD || state_d == S_EXPAND) ? idx_d : '0;
    data_d  = (state_d == S_LOAD) ? DATA_WIDTH'(word) : '0;
    blast_d = final_d && (state_d == S_LOAD || state_d == S_EXPAND ||
                          state_d == S_DONE);
    done_d  = final_q && (state_d == S_DONE);
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      one_q   <= 1'b0;
      pend_q  <= 1'b0;
      final_q <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      fsm_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      blast_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      one_q   <= one_d;
      pend_q  <= pend_d;
      final_q <= final_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      fsm_q   <= fsm_d;
      count_q <= count_d;
      data_q  <= data_d;
      blast_q <= blast_d;
      done_q  <= done_d;
    end
  end

  // Block buffer: one byte written per cycle at the byte pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLK_BYTES; i++) blk_q[i] <= '0;
    end else if (we) begin
      blk_q[ptr_q] <= wdata;
    end
  end

  assign byte_ready_out = ready_q;
  assign FSM_core_out   = fsm_q;
  assign core_count_out = count_q;
  assign data_out       = data_q;
  assign block_last_out = blast_q;
  assign msg_done_out   = done_q;

endmodule

// File: doc/sha_pad_feeder.md
# sha_pad_feeder

Message front end of the SHA-256 core. Accepts the message as a byte stream and applies SHA-256 padding: 0x80, zero fill, and the 64-bit big-endian bit length. Each 512-bit block is buffered and handed to the message-expansion block as 16 words, one per cycle, in phase code 3'b010. The block then sequences the 64-cycle expansion phase (3'b011) with the matching round counter.

## Interface
- DATA_WIDTH, 32, word width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- byte_in  in  8  message byte.
- byte_valid_in  in  1  byte_in valid.
- byte_last_in  in  1  final message byte; qualified by byte_valid_in.
- byte_ready_out  out  1  byte accepted on a cycle with valid && ready.
- empty_msg_in  in  1  one-cycle pulse requesting the hash of the zero-length message; honoured only in IDLE.
- core_ready_in  in  1  compression side can take the next block.
- FSM_core_out  out  3  phase code: 000 idle, 001 collect/pad/wait, 010 load, 011 expand, 100 block done.
- core_count_out  out  7  word/round index: 0..15 in 010, 0..63 in 011, 0 otherwise.
- data_out  out  32  block word during 010, big-endian (first byte in [31:24]); 0 otherwise.
- block_last_out  out  1  high during 010/011/100 of the message's final block.
- msg_done_out  out  1  one-cycle pulse during 100 of the final block.

## Operation
- Storage and counters:
  - 64-byte block buffer with a 6-bit byte pointer (ptr).
  - 61-bit byte counter; bit length = {count, 3'b000}, modulo 2^64.
- IDLE (000), ready=1: accepted byte → buffer[0], ptr=1, count=1 → COLLECT. A byte with last set → PAD instead. empty_msg_in with no valid byte → PAD with count=0. Valid byte and empty_msg_in together: byte wins, pulse ignored.
- COLLECT (001), ready=1: each accepted byte → buffer[ptr], ptr++, count++.
  - byte_last_in → PAD.
  - Otherwise, if ptr wraps to 0 → WAIT with pad_pending=0.
  - byte_last_in without byte_valid_in is ignored.
- PAD (001), ready=0: writes one byte per cycle at ptr, then ptr++.
  - First write is 0x80.
  - Then 0x00 until ptr==56, followed by 8 length bytes MSB first at 56..63 → WAIT with final=1.
  - If 0x80 landed at ptr≥56: zeros through 63 → WAIT with pad_pending=1. After that block, resume PAD with zeros from 0 to 55, then length.
- WAIT (001), ready=0: core_ready_in=1 → LOAD next cycle.
- LOAD (010): 16 cycles, core_count_out 0..15, data_out = buffer word[count]. core_ready_in is ignored once LOAD starts.
- EXPAND (011): 64 cycles, core_count_out 0..63, data_out=0.
- DONE (100): one cycle. block_last_out=final; msg_done_out=final. Next state:
  - final → IDLE, counters cleared.
  - pad_pending → PAD.
  - otherwise → COLLECT with ptr=0.

## Timing
- All outputs are registered; byte_ready_out is decoded from state.
- Reset values: FSM_core_out=000, core_count_out=0, data_out=0, byte_ready_out=0 while rst is high, block_last_out=0, msg_done_out=0.
- Reset also clears the buffer, ptr, the byte counter and flags, and discards any partial message.
- Reset asserted mid-LOAD/EXPAND: outputs go to reset values immediately; after release the block restarts in IDLE.
- Block completes at cycle C (byte 63 written) → WAIT at C+1. core_ready_in sampled high at cycle W → first 010 cycle at W+1.
- PAD duration = 64 − (L mod 64) cycles for the block holding the length. The 0x80-overflow case adds 64−ptr cycles before WAIT, plus 64 cycles in the next block.
- A block occupies exactly 16 + 64 + 1 = 81 cycles from first 010 to the end of 100.
- byte_ready_out is 0 from the cycle after the last byte through DONE of the final block.

## Test plan
- "abc" (61 62 63, last) with core_ready_in=1 → expected sequence:
  - One block: word0=0x61626380, words1..14=0, word15=0x00000018.
  - 010 for counts 0..15, then 011 for 0..63, then 100 with msg_done_out=1 and block_last_out=1.
- empty_msg_in in IDLE → word0=0x80000000, words1..15=0, single final block.
- 55 bytes of 0xAA → single block:
  - word13=0xAAAAAA80, word14=0, word15=0x000001B8.
  - PAD lasts 9 cycles.
- 56 bytes of 0xAA → two blocks:
  - Block 1: word14=0x80000000, word15=0, block_last_out=0.
  - Block 2: words0..14=0, word15=0x000001C0, final.
- 64 bytes with core_ready_in held low for 20 cycles after block 1 completes → FSM_core_out stays 001 and byte_ready_out=0 until ready.
  - Block 2: word0=0x80000000, word15=0x00000200.
- rst pulsed at EXPAND count 30 → all outputs 0 immediately. Fresh "abc" after release matches the first scenario.
